// File: rtl/mem_sram_pkg.sv
// Shared types and helpers for the core-port to SRAM bus adapter.
// The MEM_SRAM_BUS_ADAPTER_RANGE_CHECK_EN build uses mem_range_ok() to reject out-of-range addresses.
package mem_sram_pkg;

  localparam int unsigned MEM_WIDTH = 64;
  localparam int unsigned BYTES     = MEM_WIDTH / 8;
  localparam int unsigned OFFW      = $clog2(BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // True when the byte address falls inside an SRAM of 'limit' bytes.
  function automatic logic mem_range_ok(input logic [63:0] addr, input logic [63:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/mem_sram_bus_adapter.sv
// Bridges a req/gnt + recv/ack core memory port onto a single-port, 1-cycle-latency SRAM.
// Optional feature macro: MEM_SRAM_BUS_ADAPTER_RANGE_CHECK_EN (out-of-range requests answer with an error).
module mem_sram_bus_adapter
  import mem_sram_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 64,
  parameter int unsigned SAW   = $clog2(DEPTH)
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 mem_req,
  output logic                 mem_gnt,
  input  logic                 mem_wen,
  input  logic [WIDTH/8-1:0]   mem_strb,
  input  logic [AW-1:0]        mem_addr,
  input  logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_recv,
  input  logic                 mem_ack,
  output logic                 mem_error,
  output logic [WIDTH-1:0]     mem_rdata,
  output logic                 sram_cen,
  output logic [WIDTH/8-1:0]   sram_wstrb,
  output logic [SAW-1:0]       sram_addr,
  output logic [WIDTH-1:0]     sram_wdata,
  input  logic [WIDTH-1:0]     sram_rdata,
  input  logic                 sram_err
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned OFF    = $clog2(NBYTES);

  state_e           state_q, state_d;
  logic             accept;
  logic             range_ok;
  logic             fresh_q;
  logic             rd_q;
  logic             rerr_q;
  logic [WIDTH-1:0] rdata_hold_q;
  logic             err_hold_q;
  logic [WIDTH-1:0] rdata_now;
  logic             err_now;
  logic             addr_unused;

`ifdef MEM_SRAM_BUS_ADAPTER_RANGE_CHECK_EN
  assign range_ok = mem_range_ok(64'(mem_addr), 64'(DEPTH) * 64'(NBYTES));
  assign addr_unused = ^mem_addr[OFF-1:0];
`else
  assign range_ok = 1'b1;
  assign addr_unused = ^{mem_addr[AW-1:SAW], mem_addr[OFF-1:0]};
`endif

  // Byte address is truncated to the SRAM window with the word offset zeroed.
  assign sram_addr  = {mem_addr[SAW-1:OFF], {OFF{1'b0}}};
  assign sram_wdata = mem_wdata;

  always_comb begin
    mem_gnt    = 1'b0;
    accept     = 1'b0;
    sram_cen   = 1'b0;
    sram_wstrb = '0;
    state_d    = state_q;

    mem_gnt  = !g_reset && ((state_q == IDLE) || mem_ack);
    accept   = mem_req && mem_gnt;
    sram_cen = accept && range_ok;
    if (sram_cen && mem_wen) begin
      sram_wstrb = mem_strb;
    end

    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (mem_ack && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The cycle after accept shows the SRAM output directly; later cycles replay the captured copy.
  always_comb begin
    rdata_now = '0;
    err_now   = 1'b0;
    if (rd_q && !rerr_q) begin
      rdata_now = sram_rdata;
    end
    err_now   = rerr_q | sram_err;
    mem_recv  = (state_q == RESP);
    mem_rdata = fresh_q ? rdata_now : rdata_hold_q;
    mem_error = fresh_q ? err_now : err_hold_q;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q      <= IDLE;
      fresh_q      <= 1'b0;
      rd_q         <= 1'b0;
      rerr_q       <= 1'b0;
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= accept;
      if (accept) begin
        rd_q   <= !mem_wen;
        rerr_q <= !range_ok;
      end
      if (fresh_q) begin
        rdata_hold_q <= rdata_now;
        err_hold_q   <= err_now;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_bus_adapter.sv
// Directed bench for mem_sram_bus_adapter with a small behavioural SRAM attached.
module tb_mem_sram_bus_adapter;

  localparam int WIDTH = 64;
  localparam int DEPTH = 1024;
  localparam int AW    = 64;
  localparam int SAW   = 10;

  logic              g_clk = 1'b0;
  logic              g_reset;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_wen;
  logic [7:0]        mem_strb;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_recv;
  logic              mem_ack;
  logic              mem_error;
  logic [WIDTH-1:0]  mem_rdata;
  logic              sram_cen;
  logic [7:0]        sram_wstrb;
  logic [SAW-1:0]    sram_addr;
  logic [WIDTH-1:0]  sram_wdata;
  logic [WIDTH-1:0]  sram_rdata;
  logic              sram_err;

  logic [WIDTH-1:0]  mem [DEPTH];

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] M0   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M8   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] FULL = 64'h1122_3344_5566_7788;
  localparam logic [63:0] PART = 64'h1122_3344_AAAA_AAAA;

  mem_sram_bus_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .SAW(SAW)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata),
    .sram_cen(sram_cen), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_err(sram_err)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) begin
    sram_err <= 1'b0;
    if (sram_cen) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 8; b++) begin
        if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input string tag);
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = a; mem_wdata = d; mem_strb = s;
    settle();
    chk({tag, "_cen"}, 64'(sram_cen), 64'd1);
    chk({tag, "_wstrb"}, 64'(sram_wstrb), 64'(s));
    tick();
    mem_req = 1'b0; mem_wen = 1'b0; mem_ack = 1'b1;
    settle();
    chk({tag, "_recv"}, 64'(mem_recv), 64'd1);
    chk({tag, "_err"}, 64'(mem_error), 64'd0);
    chk({tag, "_rdata"}, mem_rdata, 64'd0);
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [63:0] exp, input string tag);
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = a; mem_strb = 8'hFF;
    settle();
    chk({tag, "_gnt"}, 64'(mem_gnt), 64'd1);
    chk({tag, "_wstrb"}, 64'(sram_wstrb), 64'd0);
    tick();
    mem_req = 1'b0; mem_ack = 1'b1;
    settle();
    chk({tag, "_recv"}, 64'(mem_recv), 64'd1);
    chk({tag, "_rdata"}, mem_rdata, exp);
    chk({tag, "_err"}, 64'(mem_error), 64'd0);
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = M0;
    mem[8] = M8;

    g_reset = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_strb = '0;
    mem_addr = '0; mem_wdata = '0; mem_ack = 1'b0;
    repeat (3) tick();
    g_reset = 1'b0;
    settle();
    chk("rst_recv", 64'(mem_recv), 64'd0);
    chk("rst_err", 64'(mem_error), 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    chk("rst_gnt", 64'(mem_gnt), 64'd1);
    chk("rst_cen", 64'(sram_cen), 64'd0);
    tick();

    // full write, readback, then partial write over the low half
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 64'h17; mem_wdata = FULL; mem_strb = 8'hFF;
    settle();
    chk("wr_addr_align", 64'(sram_addr), 64'h10);
    mem_req = 1'b0; mem_wen = 1'b0;
    do_write(64'h10, FULL, 8'hFF, "wr_full");
    do_read(64'h10, FULL, "rd_full");
    do_write(64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, "wr_part");
    do_read(64'h10, PART, "rd_part");

    // zero-strobe write leaves memory unchanged
    do_write(64'h8, 64'h5555_5555_5555_5555, 8'h00, "wr_zero");
    do_read(64'h8, M8, "rd_after_zero");

    // ack ignored while idle
    mem_ack = 1'b1;
    tick();
    chk("idle_ack_recv", 64'(mem_recv), 64'd0);
    mem_ack = 1'b0;

    // stalled response, with requests toggling while gnt is low
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h10;
    tick();
    mem_addr = 64'h0;
    for (int k = 0; k < 5; k++) begin
      mem_req = k[0];
      settle();
      chk("stall_gnt", 64'(mem_gnt), 64'd0);
      chk("stall_recv", 64'(mem_recv), 64'd1);
      chk("stall_cen", 64'(sram_cen), 64'd0);
      chk("stall_rdata", mem_rdata, PART);
      tick();
    end
    mem_req = 1'b1; mem_ack = 1'b1;
    settle();
    chk("ackreq_gnt", 64'(mem_gnt), 64'd1);
    chk("ackreq_cen", 64'(sram_cen), 64'd1);
    tick();
    mem_req = 1'b0;
    settle();
    chk("ackreq_recv", 64'(mem_recv), 64'd1);
    chk("ackreq_rdata", mem_rdata, M0);
    tick();
    mem_ack = 1'b0;
    chk("ackreq_idle", 64'(mem_recv), 64'd0);

    // back-to-back reads with ack tied high
    mem_ack = 1'b1; mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h0;
    settle();
    chk("b2b_cen0", 64'(sram_cen), 64'd1);
    tick();
    mem_addr = 64'h8;
    settle();
    chk("b2b_cen1", 64'(sram_cen), 64'd1);
    chk("b2b_recv0", 64'(mem_recv), 64'd1);
    chk("b2b_rdata0", mem_rdata, M0);
    tick();
    mem_addr = 64'h10;
    settle();
    chk("b2b_cen2", 64'(sram_cen), 64'd1);
    chk("b2b_rdata1", mem_rdata, M8);
    tick();
    mem_req = 1'b0;
    settle();
    chk("b2b_recv2", 64'(mem_recv), 64'd1);
    chk("b2b_rdata2", mem_rdata, PART);
    chk("b2b_cen_off", 64'(sram_cen), 64'd0);
    tick();
    chk("b2b_done", 64'(mem_recv), 64'd0);
    mem_ack = 1'b0;

    // address beyond the SRAM
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h2000;
    settle();
`ifdef MEM_SRAM_BUS_ADAPTER_RANGE_CHECK_EN
    chk("oor_cen", 64'(sram_cen), 64'd0);
`else
    chk("oor_cen", 64'(sram_cen), 64'd1);
`endif
    tick();
    mem_req = 1'b0; mem_ack = 1'b1;
    settle();
    chk("oor_recv", 64'(mem_recv), 64'd1);
`ifdef MEM_SRAM_BUS_ADAPTER_RANGE_CHECK_EN
    chk("oor_err", 64'(mem_error), 64'd1);
    chk("oor_rdata", mem_rdata, 64'd0);
`else
    chk("oor_err", 64'(mem_error), 64'd0);
    chk("oor_rdata", mem_rdata, M0);
`endif
    tick();
    mem_ack = 1'b0;

    // reset while a response is pending
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h10;
    tick();
    mem_req = 1'b0;
    settle();
    chk("rstresp_recv", 64'(mem_recv), 64'd1);
    g_reset = 1'b1;
    settle();
    chk("rstresp_gnt", 64'(mem_gnt), 64'd0);
    tick();
    chk("rstresp_drop", 64'(mem_recv), 64'd0);
    g_reset = 1'b0;
    tick();
    chk("rstresp_gnt1", 64'(mem_gnt), 64'd1);
    do_read(64'h10, PART, "rd_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
